// File: rtl/cprs_acc_sink.sv
// Frame accumulator for 3:2 compressor {carry,sum} beats.
// Emits saturating ones-count, beat count and overflow flag per frame.
module cprs_acc_sink #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cs,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_sat
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] ocnt_q, ocnt_d;
  logic [CNT_W-1:0] obeat_q, obeat_d;
  logic             osat_q, osat_d;

  logic             accept;
  logic [ACC_W:0]   acc_ext;
  logic             acc_ovf;
  logic             cnt_full;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_count = ocnt_q;
  assign out_beats = obeat_q;
  assign out_sat   = osat_q;

  assign accept = in_valid & in_ready;

  // in_cs read as an unsigned number is exactly 2*carry + sum
  assign acc_ext  = {1'b0, acc_q}
                  + {{(ACC_W-1){1'b0}}, in_cs};
  assign acc_ovf  = acc_ext[ACC_W];
  assign acc_nxt  = acc_ovf ? '1 : acc_ext[ACC_W-1:0];
  assign cnt_full = &cnt_q;
  assign cnt_nxt  = cnt_full ? cnt_q
                             : cnt_q + CNT_W'(1);
  assign sat_nxt  = sat_q | acc_ovf | cnt_full;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    ocnt_d  = ocnt_q;
    obeat_d = obeat_q;
    osat_d  = osat_q;
    unique case (state_q)
      ACC: begin
        if (accept) begin
          if (in_last) begin
            ocnt_d  = acc_nxt;
            obeat_d = cnt_nxt;
            osat_d  = sat_nxt;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            state_d = HOLD;
          end else begin
            acc_d = acc_nxt;
            cnt_d = cnt_nxt;
            sat_d = sat_nxt;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      ocnt_q  <= '0;
      obeat_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      ocnt_q  <= ocnt_d;
      obeat_q <= obeat_d;
      osat_q  <= osat_d;
    end
  end

endmodule

// File: tb/tb_cprs_acc_sink.sv
// Randomized and directed bench for cprs_acc_sink.
// Frame-level reference model compared every cycle.
module tb_cprs_acc_sink;

  localparam int ACC_W = 8;
  localparam int CNT_W = 6;
  localparam int AMAX  = (1 << ACC_W) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_cs = 2'b00;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_count;
  logic [CNT_W-1:0] out_beats;
  logic             out_sat;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  bit started = 0;
  bit m_valid = 0;
  int m_sum = 0;
  int m_n = 0;
  int e_count = 0;
  int e_beats = 0;
  int e_sat = 0;
  bit rand_ready = 0;

  cprs_acc_sink #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_cs(in_cs),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_count(out_count),
    .out_beats(out_beats),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // Frame-level model: sum the beats, clamp, flag overflow.
  always @(posedge clk) begin
    if (!rstn) begin
      started = 1;
      m_valid = 0;
      m_sum = 0;
      m_n = 0;
      e_count = 0;
      e_beats = 0;
      e_sat = 0;
    end else if (!m_valid) begin
      if (in_valid) begin
        m_sum += int'(in_cs);
        m_n++;
        if (in_last) begin
          e_count = (m_sum > AMAX) ? AMAX : m_sum;
          e_beats = (m_n > CMAX) ? CMAX : m_n;
          e_sat = (m_sum > AMAX || m_n > CMAX) ? 1 : 0;
          m_valid = 1;
          m_sum = 0;
          m_n = 0;
        end
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(!m_valid));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_count", int'(out_count), e_count);
      chk("out_beats", int'(out_beats), e_beats);
      chk("out_sat", int'(out_sat), e_sat);
    end
  end

  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] cs, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_cs = cs;
    in_last = last;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_cs = 2'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (!out_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk(name, 0, 1);
  endtask

  initial begin
    int len;
    logic [1:0] cs;
    // 1: reset release
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_count", int'(out_count), 0);
    chk("t1_ready", int'(in_ready), 1);

    // 2: single frame
    out_ready = 1'b1;
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b00, 1'b1);
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_count", int'(out_count), 6);
    chk("t2_beats", int'(out_beats), 4);
    chk("t2_sat", int'(out_sat), 0);
    @(negedge clk);
    chk("t2_drop", int'(out_valid), 0);

    // 3: backpressure
    out_ready = 1'b0;
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", int'(out_valid), 1);
      chk("t3_count", int'(out_count), 6);
      chk("t3_beats", int'(out_beats), 4);
      chk("t3_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready_after", int'(in_ready), 1);

    // 4: back-to-back, B held during HOLD
    out_ready = 1'b0;
    send(2'b01, 1'b0);
    send(2'b01, 1'b0);
    send(2'b01, 1'b1);
    fork
      begin
        send(2'b11, 1'b0);
        send(2'b11, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        chk("t4_a_count", int'(out_count), 3);
        chk("t4_a_beats", int'(out_beats), 3);
        out_ready = 1'b1;
      end
    join
    chk("t4_b_valid", int'(out_valid), 1);
    chk("t4_b_count", int'(out_count), 6);
    chk("t4_b_beats", int'(out_beats), 2);
    @(negedge clk);

    // 5: saturation
    for (int i = 0; i < 86; i++) send(2'b11, 1'(i == 85));
    chk("t5_count", int'(out_count), 255);
    chk("t5_beats", int'(out_beats), 63);
    chk("t5_sat", int'(out_sat), 1);
    send(2'b01, 1'b1);
    chk("t5b_count", int'(out_count), 1);
    chk("t5b_beats", int'(out_beats), 1);
    chk("t5b_sat", int'(out_sat), 0);
    @(negedge clk);

    // 6: reset mid-frame
    for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("t6_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("t6_valid2", int'(out_valid), 0);
    send(2'b01, 1'b1);
    chk("t6_count", int'(out_count), 1);
    chk("t6_beats", int'(out_beats), 1);
    @(negedge clk);

    // random frames with random backpressure and idle gaps
    rand_ready = 1;
    for (int f = 0; f < 200; f++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 100)
                                         : $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cs = 2'($urandom);
        send(cs, 1'(b == len - 1));
      end
      if ($urandom_range(0, 19) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
